// File: rtl/simd_pkg.sv
// Shared types and default shape for the SIMD AES vector register bank.
// One register holds a full 128-bit AES state split into 32-bit lanes.
package simd_pkg;

    localparam int VRB_DEPTH  = 16;
    localparam int VRB_LANES  = 4;
    localparam int VRB_LANE_W = 32;

    typedef logic [VRB_LANE_W-1:0] lane_t;
    typedef lane_t [VRB_LANES-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrb_state_e;

endpackage

// File: rtl/vrb_clear_ctrl.sv
// Bulk-clear sequencer: walks every register address once, one per cycle,
// and holds busy for exactly DEPTH cycles.
//
// state | meaning
// IDLE  | waiting for clear_req; bank available for reads/writes
// CLEAR | zeroing register[clr_addr]; reads and writes blocked
module vrb_clear_ctrl
    import simd_pkg::*;
#(
    parameter int  DEPTH  = VRB_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    vrb_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // clear_req is only sampled in IDLE, so a second pulse cannot restart a sweep
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/vector_register_bank.sv
// Multi-lane vector register file: two registered read ports, one lane-masked
// write port with write-first bypass, and a sequenced bulk clear.
module vector_register_bank
    import simd_pkg::*;
#(
    parameter int  DEPTH    = VRB_DEPTH,
    parameter int  LANES    = VRB_LANES,
    parameter int  LANE_W   = VRB_LANE_W,
    parameter bit  ZERO_REG = 1'b0,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int VEC_W    = LANES * LANE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_lane_mask,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic              clear_req,
    output logic              busy,
    output logic              q_valid,
    output logic [VEC_W-1:0]  q_a,
    output logic [VEC_W-1:0]  q_b
);

    logic [VEC_W-1:0]  mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              rd_fire;
    logic [VEC_W-1:0]  rd_val_a, rd_val_b;

    vrb_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // A clear request in the same cycle pre-empts any write or read
    assign wr_ok   = wren && !busy && !clear_req
                     && (32'(wr_addr) < DEPTH)
                     && !(ZERO_REG && (wr_addr == '0));
    assign rd_fire = rd_en && !busy && !clear_req;

    function automatic logic [VEC_W-1:0] read_val(input logic [ADDR_W-1:0] addr);
        logic [VEC_W-1:0] v;
        v = '0;
        if ((32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0))) begin
            v = mem[addr];
            if (wr_ok && (wr_addr == addr)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_lane_mask[i]) begin
                        v[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        rd_val_a = read_val(rd_addr_a);
        rd_val_b = read_val(rd_addr_b);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane_mask[i]) begin
                    mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_a     <= '0;
            q_b     <= '0;
        end else begin
            q_valid <= rd_fire;
            if (rd_fire) begin
                q_a <= rd_val_a;
                q_b <= rd_val_b;
            end
        end
    end

endmodule

// File: tb/tb_vector_register_bank.sv
// Self-checking bench for vector_register_bank: default instance driven from a
// vector table plus clear/reset sequences; a second instance covers ZERO_REG and DEPTH=12.
module tb_vector_register_bank;

    localparam int VW = 128;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          rd_en, wren, clear_req;
    logic [3:0]    rd_addr_a, rd_addr_b, wr_addr, wr_lane_mask;
    logic [VW-1:0] wr_data;
    logic          busy, q_valid;
    logic [VW-1:0] q_a, q_b;

    logic          z_rd_en, z_wren, z_clear_req;
    logic [3:0]    z_rd_addr_a, z_rd_addr_b, z_wr_addr, z_wr_lane_mask;
    logic [VW-1:0] z_wr_data;
    logic          z_busy, z_q_valid;
    logic [VW-1:0] z_q_a, z_q_b;

    always #5 clock = ~clock;

    vector_register_bank dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_en        (rd_en),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .wren         (wren),
        .wr_addr      (wr_addr),
        .wr_lane_mask (wr_lane_mask),
        .wr_data      (wr_data),
        .clear_req    (clear_req),
        .busy         (busy),
        .q_valid      (q_valid),
        .q_a          (q_a),
        .q_b          (q_b)
    );

    vector_register_bank #(.DEPTH(12), .ZERO_REG(1'b1)) dut_z (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_en        (z_rd_en),
        .rd_addr_a    (z_rd_addr_a),
        .rd_addr_b    (z_rd_addr_b),
        .wren         (z_wren),
        .wr_addr      (z_wr_addr),
        .wr_lane_mask (z_wr_lane_mask),
        .wr_data      (z_wr_data),
        .clear_req    (z_clear_req),
        .busy         (z_busy),
        .q_valid      (z_q_valid),
        .q_a          (z_q_a),
        .q_b          (z_q_b)
    );

    typedef struct {
        logic          wren;
        logic [3:0]    wa;
        logic [3:0]    mask;
        logic [VW-1:0] wd;
        logic          rd;
        logic [3:0]    ra;
        logic [3:0]    rb;
        logic [VW-1:0] ea;
        logic [VW-1:0] eb;
    } vec_rec_t;

    typedef struct {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } exp_t;

    vec_rec_t tbl [11];
    exp_t     sb [$];
    int       n_checks = 0;
    int       n_pass   = 0;

    function automatic logic [VW-1:0] rep(input logic [31:0] x);
        return {4{x}};
    endfunction

    function automatic vec_rec_t mk(input logic we, input logic [3:0] wa, input logic [3:0] mask,
                                    input logic [VW-1:0] wd, input logic rd, input logic [3:0] ra,
                                    input logic [3:0] rb, input logic [VW-1:0] ea,
                                    input logic [VW-1:0] eb);
        vec_rec_t r;
        r.wren = we; r.wa = wa; r.mask = mask; r.wd = wd;
        r.rd = rd; r.ra = ra; r.rb = rb; r.ea = ea; r.eb = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_in(input logic we, input logic [3:0] wa, input logic [3:0] mask,
                          input logic [VW-1:0] wd, input logic rd, input logic [3:0] ra,
                          input logic [3:0] rb, input logic clr);
        wren = we; wr_addr = wa; wr_lane_mask = mask; wr_data = wd;
        rd_en = rd; rd_addr_a = ra; rd_addr_b = rb; clear_req = clr;
    endtask

    task automatic idle();
        set_in(1'b0, 4'd0, 4'h0, '0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic z_set(input logic we, input logic [3:0] wa, input logic [VW-1:0] wd,
                         input logic rd, input logic [3:0] ra, input logic [3:0] rb);
        z_wren = we; z_wr_addr = wa; z_wr_lane_mask = 4'hF; z_wr_data = wd;
        z_rd_en = rd; z_rd_addr_a = ra; z_rd_addr_b = rb; z_clear_req = 1'b0;
    endtask

    // Advance one edge, then compare q_valid and pop the scoreboard when data is presented
    task automatic tick(input string name, input logic exp_valid);
        exp_t e;
        @(posedge clock);
        #1;
        check({name, "_q_valid"}, {127'd0, q_valid}, {127'd0, exp_valid});
        if (q_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL %s: q_valid high with no expected read queued", name);
            end else begin
                e = sb.pop_front();
                check({name, "_q_a"}, q_a, e.a);
                check({name, "_q_b"}, q_b, e.b);
            end
        end
    endtask

    task automatic rd_chk(input string name, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [VW-1:0] ea, input logic [VW-1:0] eb);
        set_in(1'b0, 4'd0, 4'h0, '0, 1'b1, ra, rb, 1'b0);
        sb.push_back('{ea, eb});
        tick(name, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        logic [VW-1:0] held;

        tbl[0]  = mk(0, 0,  4'h0, '0,                  1, 0, 15, '0, '0);
        tbl[1]  = mk(1, 1,  4'hF, rep(32'd5),          0, 0, 0,  '0, '0);
        tbl[2]  = mk(1, 2,  4'hF, rep(32'd255),        1, 1, 2,  rep(32'd5), rep(32'd255));
        tbl[3]  = mk(1, 3,  4'hF, rep(32'hAAAAAAAA),   0, 0, 0,  '0, '0);
        tbl[4]  = mk(1, 3,  4'h2, rep(32'h12345678),   1, 3, 1,
                     {32'hAAAAAAAA, 32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA}, rep(32'd5));
        tbl[5]  = mk(0, 0,  4'h0, '0,                  1, 3, 2,
                     {32'hAAAAAAAA, 32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA}, rep(32'd255));
        tbl[6]  = mk(1, 5,  4'h5, {32'h11, 32'h22, 32'h33, 32'h44}, 1, 5, 5,
                     {32'h0, 32'h22, 32'h0, 32'h44}, {32'h0, 32'h22, 32'h0, 32'h44});
        tbl[7]  = mk(0, 0,  4'h0, '0,                  0, 0, 0,  '0, '0);
        tbl[8]  = mk(1, 1,  4'h0, rep(32'hFFFFFFFF),   1, 1, 5,
                     rep(32'd5), {32'h0, 32'h22, 32'h0, 32'h44});
        tbl[9]  = mk(1, 15, 4'h8, rep(32'hBEEF),       1, 15, 14, {32'hBEEF, 96'h0}, '0);
        tbl[10] = mk(0, 0,  4'h0, '0,                  1, 15, 3,  {32'hBEEF, 96'h0},
                     {32'hAAAAAAAA, 32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA});

        reset_n = 1'b0;
        idle();
        z_set(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
        #12;
        check("reset_q_a", q_a, '0);
        check("reset_q_b", q_b, '0);
        check("reset_q_valid", {127'd0, q_valid}, '0);
        check("reset_busy", {127'd0, busy}, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].wren, tbl[i].wa, tbl[i].mask, tbl[i].wd,
                   tbl[i].rd, tbl[i].ra, tbl[i].rb, 1'b0);
            if (tbl[i].rd) sb.push_back('{tbl[i].ea, tbl[i].eb});
            tick($sformatf("vec%0d", i), tbl[i].rd);
            check($sformatf("vec%0d_busy", i), {127'd0, busy}, '0);
        end

        idle();
        tick("hold", 1'b0);
        check("hold_q_a", q_a, {32'hBEEF, 96'h0});
        held = q_a;

        // Clear together with a write to r4 and a read: both dropped
        set_in(1'b1, 4'd4, 4'hF, rep(32'h4444), 1'b1, 4'd1, 4'd2, 1'b1);
        tick("clr_start", 1'b0);
        check("clr_start_q_a_hold", q_a, held);
        n_busy = busy ? 1 : 0;
        for (int k = 0; k < 40 && busy; k++) begin
            idle();
            if (k == 2) clear_req = 1'b1;
            if (k == 9) set_in(1'b1, 4'd0, 4'hF, rep(32'hDD), 1'b1, 4'd1, 4'd1, 1'b0);
            tick($sformatf("clr%0d", k), 1'b0);
            if (busy) n_busy++;
        end
        check("clr_busy_cycles", VW'(n_busy), VW'(16));
        check("clr_q_a_hold", q_a, held);
        rd_chk("after_clr_r1_r2", 4'd1, 4'd2, '0, '0);
        rd_chk("after_clr_r4_r0", 4'd4, 4'd0, '0, '0);
        rd_chk("after_clr_r3_r15", 4'd3, 4'd15, '0, '0);

        // Reset in the middle of a clear sweep
        set_in(1'b1, 4'd6, 4'hF, rep(32'h77), 1'b0, 4'd0, 4'd0, 1'b0);
        tick("wr_r6", 1'b0);
        rd_chk("rd_r6", 4'd6, 4'd6, rep(32'h77), rep(32'h77));
        set_in(1'b0, 4'd0, 4'h0, '0, 1'b0, 4'd0, 4'd0, 1'b1);
        tick("clr2_start", 1'b0);
        idle();
        for (int k = 0; k < 4; k++) tick($sformatf("clr2_%0d", k), 1'b0);
        check("clr2_busy_before_reset", {127'd0, busy}, {127'd0, 1'b1});
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {127'd0, busy}, '0);
        check("midrst_q_valid", {127'd0, q_valid}, '0);
        check("midrst_q_a", q_a, '0);
        check("midrst_q_b", q_b, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_in(1'b1, 4'd7, 4'hF, rep(32'd9), 1'b0, 4'd0, 4'd0, 1'b0);
        tick("post_rst_wr", 1'b0);
        check("post_rst_busy", {127'd0, busy}, '0);
        rd_chk("post_rst_rd", 4'd7, 4'd6, rep(32'd9), '0);
        idle();

        // ZERO_REG=1, DEPTH=12 instance
        z_set(1'b1, 4'd0, rep(32'd7), 1'b1, 4'd0, 4'd0);
        @(posedge clock); #1;
        check("z_valid", {127'd0, z_q_valid}, {127'd0, 1'b1});
        check("z_r0_bypass_a", z_q_a, '0);
        check("z_r0_bypass_b", z_q_b, '0);
        z_set(1'b1, 4'd11, rep(32'h42), 1'b1, 4'd0, 4'd13);
        @(posedge clock); #1;
        check("z_r0_after_wr", z_q_a, '0);
        check("z_rd_13", z_q_b, '0);
        z_set(1'b1, 4'd14, rep(32'd3), 1'b1, 4'd14, 4'd11);
        @(posedge clock); #1;
        check("z_rd_14_bypass", z_q_a, '0);
        check("z_rd_r11", z_q_b, rep(32'h42));
        z_set(1'b1, 4'd2, rep(32'd2), 1'b1, 4'd2, 4'd14);
        @(posedge clock); #1;
        check("z_r2_bypass", z_q_a, rep(32'd2));
        check("z_rd_14", z_q_b, '0);
        z_set(1'b0, 4'd0, '0, 1'b1, 4'd11, 4'd2);
        @(posedge clock); #1;
        check("z_r11_intact", z_q_a, rep(32'h42));
        check("z_r2_stored", z_q_b, rep(32'd2));
        z_set(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
